// File: rtl/pong_game_ctrl.sv
// Round/score sequencer for the pong ball: serve delay, play, pause and game-over timing.
// All outputs are registered. Button and score inputs act on rising edges only.
module pong_game_ctrl #(
  parameter int WIN_SCORE    = 7,
  parameter int SERVE_FRAMES = 60,
  parameter int OVER_FRAMES  = 180,
  parameter int SCORE_W      = 4
) (
  input  logic               in_clock,
  input  logic               in_reset_n,
  input  logic               in_ani_stb,
  input  logic               in_btn_start,
  input  logic               in_btn_pause,
  input  logic               in_left_score,
  input  logic               in_right_score,
  output logic               out_ball_reset,
  output logic               out_ball_start,
  output logic               out_animate,
  output logic [SCORE_W-1:0] out_left_points,
  output logic [SCORE_W-1:0] out_right_points,
  output logic [1:0]         out_winner,
  output logic [2:0]         out_state
);

  localparam int CNT_MAX = (SERVE_FRAMES > OVER_FRAMES) ? SERVE_FRAMES : OVER_FRAMES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0]   C_SERVE = CNT_W'(SERVE_FRAMES);
  localparam logic [CNT_W-1:0]   C_OVER  = CNT_W'(OVER_FRAMES);
  localparam logic [CNT_W-1:0]   C_ONE   = CNT_W'(1);
  localparam logic [SCORE_W-1:0] C_WIN   = SCORE_W'(WIN_SCORE);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SERVE = 3'd1,
    S_PLAY  = 3'd2,
    S_PAUSE = 3'd3,
    S_OVER  = 3'd4
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [SCORE_W-1:0] r_left, w_left_nxt, w_left_inc;
  logic [SCORE_W-1:0] r_right, w_right_nxt, w_right_inc;
  logic [1:0]         r_winner, w_winner_nxt;
  logic               r_ball_reset, w_ball_reset_nxt;
  logic               r_ball_start, w_ball_start_nxt;
  logic               r_animate, w_animate_nxt;
  logic               r_prev_start, r_prev_pause, r_prev_left, r_prev_right;
  logic               w_start_rise, w_pause_rise, w_left_rise, w_right_rise;
  logic               w_restart;

  assign w_start_rise = in_btn_start   & ~r_prev_start;
  assign w_pause_rise = in_btn_pause   & ~r_prev_pause;
  assign w_left_rise  = in_left_score  & ~r_prev_left;
  assign w_right_rise = in_right_score & ~r_prev_right;

  // Saturate so a point counter can never pass WIN_SCORE or wrap.
  assign w_left_inc  = (r_left  >= C_WIN) ? r_left  : r_left  + SCORE_W'(1);
  assign w_right_inc = (r_right >= C_WIN) ? r_right : r_right + SCORE_W'(1);

  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_left_nxt       = r_left;
    w_right_nxt      = r_right;
    w_winner_nxt     = r_winner;
    w_ball_reset_nxt = 1'b0;
    w_ball_start_nxt = 1'b0;
    w_restart        = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_restart = w_start_rise;
      end
      S_SERVE: begin
        if (in_ani_stb) begin
          if (r_cnt <= C_ONE) begin
            w_cnt_nxt        = '0;
            w_state_nxt      = S_PLAY;
            w_ball_start_nxt = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt - C_ONE;
          end
        end
      end
      S_PLAY: begin
        if (w_pause_rise) begin
          w_state_nxt = S_PAUSE;
        end else if (w_left_rise) begin
          w_left_nxt = w_left_inc;
          if (w_left_inc == C_WIN) begin
            w_winner_nxt = 2'b01;
            w_cnt_nxt    = C_OVER;
            w_state_nxt  = S_OVER;
          end else begin
            w_cnt_nxt   = C_SERVE;
            w_state_nxt = S_SERVE;
          end
        end else if (w_right_rise) begin
          w_right_nxt = w_right_inc;
          if (w_right_inc == C_WIN) begin
            w_winner_nxt = 2'b10;
            w_cnt_nxt    = C_OVER;
            w_state_nxt  = S_OVER;
          end else begin
            w_cnt_nxt   = C_SERVE;
            w_state_nxt = S_SERVE;
          end
        end
      end
      S_PAUSE: begin
        if (w_start_rise) begin
          w_restart = 1'b1;
        end else if (w_pause_rise) begin
          w_state_nxt = S_PLAY;
        end
      end
      S_OVER: begin
        if (w_start_rise) begin
          w_restart = 1'b1;
        end else if (in_ani_stb) begin
          if (r_cnt <= C_ONE) begin
            w_cnt_nxt   = '0;
            w_state_nxt = S_IDLE;
          end else begin
            w_cnt_nxt = r_cnt - C_ONE;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // A new game wipes the scoreboard and recentres the ball before serving.
    if (w_restart) begin
      w_left_nxt       = '0;
      w_right_nxt      = '0;
      w_winner_nxt     = 2'b00;
      w_ball_reset_nxt = 1'b1;
      w_cnt_nxt        = C_SERVE;
      w_state_nxt      = S_SERVE;
    end
  end

  assign w_animate_nxt = (w_state_nxt == S_SERVE) || (w_state_nxt == S_PLAY);

  always_ff @(posedge in_clock or negedge in_reset_n) begin
    if (!in_reset_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_left       <= '0;
      r_right      <= '0;
      r_winner     <= 2'b00;
      r_ball_reset <= 1'b0;
      r_ball_start <= 1'b0;
      r_animate    <= 1'b0;
      r_prev_start <= 1'b0;
      r_prev_pause <= 1'b0;
      r_prev_left  <= 1'b0;
      r_prev_right <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_left       <= w_left_nxt;
      r_right      <= w_right_nxt;
      r_winner     <= w_winner_nxt;
      r_ball_reset <= w_ball_reset_nxt;
      r_ball_start <= w_ball_start_nxt;
      r_animate    <= w_animate_nxt;
      r_prev_start <= in_btn_start;
      r_prev_pause <= in_btn_pause;
      r_prev_left  <= in_left_score;
      r_prev_right <= in_right_score;
    end
  end

  assign out_ball_reset   = r_ball_reset;
  assign out_ball_start   = r_ball_start;
  assign out_animate      = r_animate;
  assign out_left_points  = r_left;
  assign out_right_points = r_right;
  assign out_winner       = r_winner;
  assign out_state        = r_state;

endmodule
